// File: rtl/dot_fetch_pkg.sv
// ---------------------------------------------------------------------------
// dot_fetch_pkg
// Shared definitions for the dot-product fetch engine (dot_row_col_fetch).
//   - state_t      : FSM state encoding (3 bits)
//   - accWidthOk() : constant function; true when the accumulator is wide
//                    enough to hold len full-width products without overflow
// ---------------------------------------------------------------------------
package dot_fetch_pkg;

    // FSM states of the fetch / multiply-accumulate sequencer.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_A  = 3'd1,
        WAIT_A = 3'd2,
        REQ_B  = 3'd3,
        WAIT_B = 3'd4,
        MAC    = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Each product needs 2*dataWidth bits and up to 2**lenWidth-1 of them are
    // summed, so lenWidth extra bits guarantee the sum never overflows.
    function automatic bit accWidthOk(input int accWidth,
                                      input int dataWidth,
                                      input int lenWidth);
        return accWidth >= (2 * dataWidth + lenWidth);
    endfunction

endpackage

// File: rtl/dot_mac.sv
// ---------------------------------------------------------------------------
// dot_mac
// Accumulator register plus unsigned multiplier for the dot-product engine.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset, clears the accumulator
//   clr   in   clears the accumulator (start of a new dot product)
//   en    in   adds op_a*op_b to the accumulator this cycle
//   op_a  in   DATA_WIDTH unsigned operand
//   op_b  in   DATA_WIDTH unsigned operand
//   acc   out  ACC_WIDTH running sum
// ---------------------------------------------------------------------------
module dot_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [ACC_WIDTH-1:0]  acc
);

    logic [2*DATA_WIDTH-1:0] w_product;
    logic [ACC_WIDTH-1:0]    r_acc;

    // The full double-width product is kept and then zero-extended, so no
    // operand bits are ever lost before accumulation.
    assign w_product = op_a * op_b;

    // Accumulator: clear has priority over accumulate so that a start that
    // coincides with a stray enable still begins from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + ACC_WIDTH'(w_product);
        end
    end

    assign acc = r_acc;

endmodule

// File: rtl/dot_row_col_fetch.sv
// ---------------------------------------------------------------------------
// dot_row_col_fetch
// Dot-product engine sitting downstream of the latency memory. On each start
// it fetches len strided A elements and len strided B elements (A before B,
// one request outstanding), multiply-accumulates the pairs and presents one
// result word.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle request, only honoured in IDLE
//   a_base, a_stride    A element 0 address and per-element increment
//   b_base, b_stride    B element 0 address and per-element increment
//   len                 number of element pairs (0 allowed)
//   mem_init, mem_addr  read request pulse and address to memory
//   mem_busy, mem_data  memory busy flag and read data
//   busy                high while a dot product is in progress
//   done                one-cycle completion pulse
//   result              dot product, held until the next accepted start
// ---------------------------------------------------------------------------
module dot_row_col_fetch
    import dot_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] a_base,
    input  logic [ADDR_WIDTH-1:0] a_stride,
    input  logic [ADDR_WIDTH-1:0] b_base,
    input  logic [ADDR_WIDTH-1:0] b_stride,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  mem_init,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_busy,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  result
);

    if (!accWidthOk(ACC_WIDTH, DATA_WIDTH, LEN_WIDTH)) begin : gAccWidthCheck
        $error("dot_row_col_fetch: ACC_WIDTH must be >= 2*DATA_WIDTH+LEN_WIDTH");
    end

    state_t                r_state;
    state_t                w_stateNext;
    logic [ADDR_WIDTH-1:0] r_aPtr;
    logic [ADDR_WIDTH-1:0] r_bPtr;
    logic [ADDR_WIDTH-1:0] r_aStride;
    logic [ADDR_WIDTH-1:0] r_bStride;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_idx;
    logic [DATA_WIDTH-1:0] r_opA;
    logic [DATA_WIDTH-1:0] r_opB;
    logic                  r_waitFirst;
    logic [ACC_WIDTH-1:0]  r_result;
    logic [ACC_WIDTH-1:0]  w_acc;
    logic                  w_accClr;
    logic                  w_accEn;
    logic                  w_lastPair;
    logic                  w_dataReady;

    // The index is widened by one bit before the compare so idx+1 can never
    // wrap back onto a small len.
    assign w_lastPair = (({1'b0, r_idx} + 1'b1) == {1'b0, r_len});

    // Memory asserts busy from a registered path, so the first wait cycle may
    // still show busy low from before the request; it is always skipped.
    assign w_dataReady = !r_waitFirst && !mem_busy;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic plus the accumulator controls. A start with len==0
    // skips every fetch and goes straight to DONE with a cleared accumulator.
    always_comb begin
        w_stateNext = r_state;
        w_accClr    = 1'b0;
        w_accEn     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accClr    = 1'b1;
                    w_stateNext = (len == '0) ? DONE : REQ_A;
                end
            end
            REQ_A:  w_stateNext = WAIT_A;
            WAIT_A: begin
                if (w_dataReady) begin
                    w_stateNext = REQ_B;
                end
            end
            REQ_B:  w_stateNext = WAIT_B;
            WAIT_B: begin
                if (w_dataReady) begin
                    w_stateNext = MAC;
                end
            end
            MAC: begin
                w_accEn     = 1'b1;
                w_stateNext = w_lastPair ? DONE : REQ_A;
            end
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Datapath registers: operand capture, pointer/index stepping and the
    // result latch. Inputs are copied at start so the requester is free to
    // change them afterwards. Pointers wrap naturally at ADDR_WIDTH bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aPtr      <= '0;
            r_bPtr      <= '0;
            r_aStride   <= '0;
            r_bStride   <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_opA       <= '0;
            r_opB       <= '0;
            r_waitFirst <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_aPtr    <= a_base;
                        r_bPtr    <= b_base;
                        r_aStride <= a_stride;
                        r_bStride <= b_stride;
                        r_len     <= len;
                        r_idx     <= '0;
                    end
                end
                REQ_A, REQ_B: begin
                    r_waitFirst <= 1'b1;
                end
                WAIT_A: begin
                    r_waitFirst <= 1'b0;
                    if (w_dataReady) begin
                        r_opA <= mem_data;
                    end
                end
                WAIT_B: begin
                    r_waitFirst <= 1'b0;
                    if (w_dataReady) begin
                        r_opB <= mem_data;
                    end
                end
                MAC: begin
                    r_aPtr <= r_aPtr + r_aStride;
                    r_bPtr <= r_bPtr + r_bStride;
                    r_idx  <= r_idx + 1'b1;
                end
                DONE: begin
                    r_result <= w_acc;
                end
                default: begin
                    r_waitFirst <= 1'b0;
                end
            endcase
        end
    end

    dot_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_accClr),
        .en   (w_accEn),
        .op_a (r_opA),
        .op_b (r_opB),
        .acc  (w_acc)
    );

    // Outputs. The address follows whichever operand is being fetched and is
    // stable for the whole request because pointers only move in MAC. In
    // DONE the accumulator already holds the final sum, so it is forwarded
    // directly; from then on the latched copy keeps the value.
    assign mem_init = (r_state == REQ_A) || (r_state == REQ_B);
    assign mem_addr = ((r_state == REQ_B) || (r_state == WAIT_B)) ? r_bPtr : r_aPtr;
    assign busy     = (r_state != IDLE) && (r_state != DONE);
    assign done     = (r_state == DONE);
    assign result   = (r_state == DONE) ? w_acc : r_result;

endmodule
